entity_loader: RTL and testbench

//  Host-side writer for the frame buffer controller's nine entity channels. Receives entity

---
 rtl/entity_loader.sv | 137 +++++++++++++
 tb/tb_entity_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/entity_loader.sv
// Entity descriptor loader: assembles 3-transfer words from the MCU into shadow slots and
// copies shadow to live at the first vsync edge after a COMMIT. Optional build macro: ENTITY_LOADER_PARITY_EN.
module entity_loader #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit VSYNC_POL      = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [6:0]   ui_data,
  input  logic         ui_strobe,
  input  logic         vsync,
  output logic [125:0] entities_o,
  output logic         commit_pend,
  output logic         err,
  output logic [1:0]   fsm_state
);

  // Handshake: each edge of ui_strobe marks one transfer; ui_data must be stable around it.
  typedef enum logic [1:0] {IDLE = 2'd0, GOT0 = 2'd1, GOT1 = 2'd2} state_t;

  localparam int              CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [13:0]     EMPTY   = 14'h3C00;

  logic           strobe_s1, strobe_s2, strobe_prev;
  logic [6:0]     data_s1, data_s2;
  logic           vs_s1, vs_s2, vs_prev;
  state_t         state;
  logic [6:0]     t0, t1;
  logic [CW-1:0]  tcnt;
  logic [8:0][13:0] shadow;

  logic        accept;
  logic        frame_edge;
  logic        is_commit;
  logic [13:0] word;
  logic        par_ok;
  logic        unused_bits;

  assign accept     = strobe_s2 ^ strobe_prev;
  assign frame_edge = (vs_s2 == VSYNC_POL) && (vs_prev != VSYNC_POL);
  assign is_commit  = (data_s2[6:3] == 4'hF);
  assign word       = {t0[2:0], t1, data_s2[6:3]};
  assign fsm_state  = state;
  assign unused_bits = ^data_s2[2:0];

`ifdef ENTITY_LOADER_PARITY_EN
  assign par_ok = ^{t0, t1, data_s2};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_s1   <= 1'b0;
      strobe_s2   <= 1'b0;
      strobe_prev <= 1'b0;
      data_s1     <= '0;
      data_s2     <= '0;
      vs_s1       <= ~VSYNC_POL;
      vs_s2       <= ~VSYNC_POL;
      vs_prev     <= ~VSYNC_POL;
    end else begin
      strobe_s1   <= ui_strobe;
      strobe_s2   <= strobe_s1;
      strobe_prev <= strobe_s2;
      data_s1     <= ui_data;
      data_s2     <= data_s1;
      vs_s1       <= vsync;
      vs_s2       <= vs_s1;
      vs_prev     <= vs_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      t0          <= '0;
      t1          <= '0;
      tcnt        <= '0;
      commit_pend <= 1'b0;
      err         <= 1'b0;
      shadow      <= {9{EMPTY}};
      entities_o  <= {9{EMPTY}};
    end else begin
      // Copy reads pre-write shadow, so a same-cycle write lands only in shadow.
      if (frame_edge && commit_pend) begin
        entities_o  <= shadow;
        commit_pend <= 1'b0;
      end else if (accept && (state == IDLE) && is_commit) begin
        commit_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          tcnt <= '0;
          if (accept && !is_commit) begin
            t0    <= data_s2;
            state <= GOT0;
          end
        end
        GOT0: begin
          if (accept) begin
            t1    <= data_s2;
            tcnt  <= '0;
            state <= GOT1;
          end else if (tcnt == TO_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GOT1: begin
          if (accept) begin
            tcnt  <= '0;
            state <= IDLE;
            if ((t0[6:3] < 4'd9) && par_ok) begin
              for (int i = 0; i < 9; i++) begin
                if (t0[6:3] == 4'(i)) shadow[i] <= word;
              end
            end else begin
              err <= 1'b1;
            end
          end else if (tcnt == TO_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_entity_loader.sv
// Directed bench for entity_loader: builds transfers from descriptor fields and checks live
// slots, commit_pend, err and FSM state against hand-computed values.
`timescale 1ns/1ps
module tb_entity_loader;

  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [6:0]   ui_data;
  logic         ui_strobe;
  logic         vsync;
  logic [125:0] entities_o;
  logic         commit_pend;
  logic         err;
  logic [1:0]   fsm_state;

  logic [13:0]  exp_live[9];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  entity_loader #(.TIMEOUT_CYCLES(TO), .VSYNC_POL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ui_data(ui_data), .ui_strobe(ui_strobe), .vsync(vsync),
    .entities_o(entities_o), .commit_pend(commit_pend), .err(err), .fsm_state(fsm_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [125:0] obs, input logic [125:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [125:0] exp_vec();
    logic [125:0] v;
    for (int i = 0; i < 9; i++) v[14*i +: 14] = exp_live[i];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ui_data = '0;
    ui_strobe = 1'b0;
    vsync = 1'b1;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    for (int i = 0; i < 9; i++) exp_live[i] = 14'h3C00;
  endtask

  // One transfer; with_edge drops vsync together with the strobe toggle.
  task automatic send_raw(input logic [6:0] d, input bit with_edge);
    ui_data = d;
    tick(4);
    ui_strobe = ~ui_strobe;
    if (with_edge) vsync = 1'b0;
    tick(4);
    if (with_edge) begin
      vsync = 1'b1;
      tick(4);
    end
  endtask

  task automatic send_word(input logic [3:0] slot, input logic [3:0] id, input logic [1:0] orient,
                           input logic [7:0] loc, input bit flip, input bit with_edge);
    logic [6:0] t0, t1, t2;
    t0 = {slot, id[3:1]};
    t1 = {id[0], orient, loc[7:4]};
    t2 = {loc[3:0], 3'b000};
    t2[0] = ~(^{t0, t1, t2}) ^ flip;
    send_raw(t0, 1'b0);
    send_raw(t1, 1'b0);
    send_raw(t2, with_edge);
  endtask

  task automatic commit(input bit with_edge);
    send_raw(7'h78, with_edge);
  endtask

  task automatic frame();
    vsync = 1'b0;
    tick(5);
    vsync = 1'b1;
    tick(5);
  endtask

  initial begin
    // 1. reset state
    do_reset();
    check_val("reset_live", entities_o, exp_vec());
    check_val("reset_pend", commit_pend, 1'b0);
    check_val("reset_err", err, 1'b0);
    check_val("reset_state", fsm_state, 2'd0);

    // 2. slot3 write, held back until COMMIT + frame edge
    send_word(4'd3, 4'h2, 2'b01, 8'h5A, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      frame();
      check_val("nocommit_live", entities_o, exp_vec());
    end
    commit(1'b0);
    check_val("commit_pend_set", commit_pend, 1'b1);
    vsync = 1'b0;
    tick(2);
    check_val("pre_edge_live", entities_o, exp_vec());
    tick(1);
    exp_live[3] = 14'h095A;
    check_val("post_edge_live", entities_o, exp_vec());
    check_val("post_edge_pend", commit_pend, 1'b0);
    vsync = 1'b1;
    tick(5);

    // 4. timeout mid-word, then recovery
    send_raw({4'd0, 3'b000}, 1'b0);
    tick(TO - 5);
    check_val("pre_timeout_err", err, 1'b0);
    check_val("pre_timeout_state", fsm_state, 2'd1);
    tick(10);
    check_val("timeout_err", err, 1'b1);
    check_val("timeout_state", fsm_state, 2'd0);
    send_word(4'd0, 4'h1, 2'b10, 8'h33, 1'b0, 1'b0);
    commit(1'b0);
    frame();
    exp_live[0] = 14'h0633;
    check_val("recover_live", entities_o, exp_vec());

    // 3. bad slot is consumed and flagged
    do_reset();
    send_word(4'hB, 4'h4, 2'b11, 8'h12, 1'b0, 1'b0);
    check_val("badslot_err", err, 1'b1);
    check_val("badslot_state", fsm_state, 2'd0);
    commit(1'b0);
    frame();
    check_val("badslot_live", entities_o, exp_vec());

    // 5. simultaneous events
    do_reset();
    send_word(4'd1, 4'h3, 2'b11, 8'hC4, 1'b0, 1'b0);
    commit(1'b0);
    send_word(4'd2, 4'h7, 2'b00, 8'h01, 1'b0, 1'b1);
    exp_live[1] = 14'h0FC4;
    check_val("write_on_edge_live", entities_o, exp_vec());
    check_val("write_on_edge_pend", commit_pend, 1'b0);
    commit(1'b1);
    check_val("commit_on_edge_live", entities_o, exp_vec());
    check_val("commit_on_edge_pend", commit_pend, 1'b1);
    frame();
    exp_live[2] = 14'h1C01;
    check_val("deferred_live", entities_o, exp_vec());
    check_val("deferred_pend", commit_pend, 1'b0);
    commit(1'b0);
    commit(1'b0);
    check_val("double_commit_pend", commit_pend, 1'b1);
    frame();
    check_val("double_commit_clr", commit_pend, 1'b0);
    send_word(4'd4, 4'h0, 2'b01, 8'hFF, 1'b0, 1'b0);
    frame();
    check_val("single_copy_live", entities_o, exp_vec());
    check_val("clean_err", err, 1'b0);

    // 6. flipped parity bit
    do_reset();
    send_word(4'd5, 4'h5, 2'b10, 8'h80, 1'b1, 1'b0);
    commit(1'b0);
    frame();
`ifdef ENTITY_LOADER_PARITY_EN
    check_val("parity_err", err, 1'b1);
`else
    exp_live[5] = 14'h1680;
    check_val("parity_err", err, 1'b0);
`endif
    check_val("parity_live", entities_o, exp_vec());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
